// File: rtl/seg7_pkg.sv
// Shared types and the active-low hex glyph table for the 7-segment display path.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_OFF = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, active-low; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG7_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = SEG7_GLYPHS[nibble];

endmodule

// File: rtl/seg7_mux_scanner.sv
// Snapshots a packed hex value and scans it onto a common-anode multiplexed display.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module seg7_mux_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
)
(
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  LOAD,
    input  logic [DIGITS-1:0]     BLANK,
    output seg7_t                 SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int VAL_W = 4 * DIGITS;

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [VAL_W-1:0]  pending;
    logic [VAL_W-1:0]  active;
    logic [VAL_W-1:0]  active_nxt;
    logic              pend_vld;
    logic              tick;
    logic              wrap;
    logic [3:0]        nibble;
    seg7_t             glyph;
    logic [DIGITS-1:0] an_nxt;
    logic [DIGITS-1:0] lz_mask;
    logic              dark;

    assign tick = (cnt == CNT_W'(PRESCALE - 1));
    assign wrap = tick && (idx == IDX_W'(DIGITS - 1));

    // The pins are updated from the next-state view, so the first digit of a
    // frame already shows the value promoted at that same wrap edge.
    always_comb begin
        idx_nxt    = wrap ? '0 : idx + IDX_W'(1);
        active_nxt = active;
        if (wrap) begin
            if (LOAD)
                active_nxt = VALUE;
            else if (pend_vld)
                active_nxt = pending;
        end
    end

    always_comb begin
        nibble = '0;
        an_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nibble    = active_nxt[4*i +: 4];
                an_nxt[i] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;

    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (active_nxt[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign dark = |((BLANK | lz_mask) & ~an_nxt);

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cnt      <= '0;
            idx      <= '0;
            pending  <= '0;
            active   <= '0;
            pend_vld <= 1'b0;
            SEG      <= SEG7_OFF;
            AN       <= '1;
            FRAME    <= 1'b0;
        end else begin
            FRAME  <= wrap;
            cnt    <= tick ? '0 : cnt + CNT_W'(1);
            active <= active_nxt;
            if (tick) begin
                idx <= idx_nxt;
                AN  <= an_nxt;
                SEG <= dark ? SEG7_OFF : glyph;
            end
            // A load on the wrap cycle bypasses pending and lands in active directly.
            if (wrap) begin
                pend_vld <= 1'b0;
            end else if (LOAD) begin
                pending  <= VALUE;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule
